// File: rtl/write_test_sequencer_if.sv
// write_test_sequencer_if: host/datapath-facing signals of the write test sequencer.
// master = host/testbench side, slave = sequencer side.
interface write_test_sequencer_if;
  logic        start;
  logic        abort;
  logic [31:0] transfer_words;
  logic        wr_strobe;
  logic        rd_valid;
  logic [31:0] error_count;
  logic        fifo_rst;
  logic        pattern_rst;
  logic        timer_on;
  logic [63:0] clk_counts;
  logic [31:0] words_written;
  logic [31:0] words_checked;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic [2:0]  state;

  modport master (
    output start, abort, transfer_words, wr_strobe, rd_valid, error_count,
    input  fifo_rst, pattern_rst, timer_on, clk_counts, words_written, words_checked,
           busy, done, status, state
  );

  modport slave (
    input  start, abort, transfer_words, wr_strobe, rd_valid, error_count,
    output fifo_rst, pattern_rst, timer_on, clk_counts, words_written, words_checked,
           busy, done, status, state
  );
endinterface

// File: rtl/write_test_sequencer.sv
// write_test_sequencer: sequences FIFO/checker reset, cycle-exact write timing and word
// accounting for the pipe-in write throughput test, ending the run once the programmed
// number of words has been written and checked.
// Optional idle-write watchdog is built only when WTS_TIMEOUT_EN is defined.
module write_test_sequencer #(
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                   okClk,
  input logic                   reset_n,
  write_test_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StArmed = 3'd2,
    StRun   = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } state_e;

  localparam logic [2:0] StatOk      = 3'd0;
  localparam logic [2:0] StatErr     = 3'd1;
  localparam logic [2:0] StatAbort   = 3'd2;
  localparam logic [2:0] StatTimeout = 3'd3;
  localparam logic [2:0] StatOverrun = 3'd4;

  localparam logic [31:0] ClearLast  = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] TimeoutLim = 32'(TIMEOUT_CYCLES);

  state_e      r_state, w_state_d;
  logic [31:0] r_len, w_len_d;
  logic [31:0] r_clr_cnt, w_clr_cnt_d;
  logic [63:0] r_clk_counts, w_clk_counts_d;
  logic [31:0] r_words_written, w_words_written_d;
  logic [31:0] r_words_checked, w_words_checked_d;
  logic        r_overrun, w_overrun_d;
  logic [2:0]  r_status, w_status_d;
  logic        r_fifo_rst, r_pattern_rst, r_timer_on, r_busy, r_done;

  logic        w_in_run_phase;
  logic [31:0] w_written_inc;
  logic [31:0] w_checked_inc;
  logic        w_timeout;

  assign w_in_run_phase = (r_state == StArmed) || (r_state == StRun) || (r_state == StDrain);
  assign w_written_inc  = r_words_written + 32'd1;
  // Checked count saturates at the latched length.
  assign w_checked_inc  = (bus.rd_valid && (r_words_checked != r_len)) ?
                          r_words_checked + 32'd1 : r_words_checked;

`ifdef WTS_TIMEOUT_EN
  logic [31:0] r_wdog, w_wdog_d;

  // Idle watchdog: any write or checked beat restarts the count.
  always_comb begin
    w_wdog_d  = '0;
    w_timeout = 1'b0;
    if (w_in_run_phase && !(bus.wr_strobe || bus.rd_valid)) begin
      w_wdog_d  = r_wdog + 32'd1;
      w_timeout = (w_wdog_d == TimeoutLim);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_wdog_d;
    end
  end
`else
  // Watchdog compiled out: a run waits indefinitely (limit kept only as a reference).
  assign w_timeout = (TimeoutLim == 32'd0) && 1'b0;
`endif

  // Next-state, counters and final status.
  always_comb begin
    w_state_d         = r_state;
    w_len_d           = r_len;
    w_clr_cnt_d       = r_clr_cnt;
    w_clk_counts_d    = r_clk_counts;
    w_words_written_d = r_words_written;
    w_words_checked_d = r_words_checked;
    w_overrun_d       = r_overrun;
    w_status_d        = r_status;

    case (r_state)
      StIdle, StDone: begin
        // Abort wins over a coincident start.
        if (bus.start && !bus.abort && (bus.transfer_words != 32'd0)) begin
          w_len_d           = bus.transfer_words;
          w_clr_cnt_d       = '0;
          w_clk_counts_d    = '0;
          w_words_written_d = '0;
          w_words_checked_d = '0;
          w_overrun_d       = 1'b0;
          w_status_d        = StatOk;
          w_state_d         = StClear;
        end
      end
      StClear: begin
        if (bus.abort) begin
          w_state_d  = StDone;
          w_status_d = StatAbort;
        end else if (r_clr_cnt == ClearLast) begin
          w_state_d = StArmed;
        end else begin
          w_clr_cnt_d = r_clr_cnt + 32'd1;
        end
      end
      StArmed: begin
        if (bus.abort) begin
          w_state_d  = StDone;
          w_status_d = StatAbort;
        end else if (w_timeout) begin
          w_state_d  = StDone;
          w_status_d = StatTimeout;
        end else begin
          w_words_checked_d = w_checked_inc;
          // The first write is both counted and timed.
          if (bus.wr_strobe) begin
            w_clk_counts_d    = r_clk_counts + 64'd1;
            w_words_written_d = w_written_inc;
            w_state_d         = (w_written_inc == r_len) ? StDrain : StRun;
          end
        end
      end
      StRun: begin
        if (bus.abort) begin
          w_state_d  = StDone;
          w_status_d = StatAbort;
        end else if (w_timeout) begin
          w_state_d  = StDone;
          w_status_d = StatTimeout;
        end else begin
          w_clk_counts_d    = r_clk_counts + 64'd1;
          w_words_checked_d = w_checked_inc;
          if (bus.wr_strobe) begin
            w_words_written_d = w_written_inc;
            if (w_written_inc == r_len) w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (bus.abort) begin
          w_state_d  = StDone;
          w_status_d = StatAbort;
        end else if (w_timeout) begin
          w_state_d  = StDone;
          w_status_d = StatTimeout;
        end else begin
          w_words_checked_d = w_checked_inc;
          // Writes past the programmed length are flagged, never counted.
          if (bus.wr_strobe) w_overrun_d = 1'b1;
          if (w_checked_inc == r_len) begin
            w_state_d = StDone;
            if (r_overrun || bus.wr_strobe) begin
              w_status_d = StatOverrun;
            end else if (bus.error_count != 32'd0) begin
              w_status_d = StatErr;
            end else begin
              w_status_d = StatOk;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= StIdle;
      r_len           <= '0;
      r_clr_cnt       <= '0;
      r_clk_counts    <= '0;
      r_words_written <= '0;
      r_words_checked <= '0;
      r_overrun       <= 1'b0;
      r_status        <= StatOk;
    end else begin
      r_state         <= w_state_d;
      r_len           <= w_len_d;
      r_clr_cnt       <= w_clr_cnt_d;
      r_clk_counts    <= w_clk_counts_d;
      r_words_written <= w_words_written_d;
      r_words_checked <= w_words_checked_d;
      r_overrun       <= w_overrun_d;
      r_status        <= w_status_d;
    end
  end

  // Control outputs registered from next state so they align with the state output.
  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_rst    <= 1'b0;
      r_pattern_rst <= 1'b0;
      r_timer_on    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_fifo_rst    <= (w_state_d == StClear);
      r_pattern_rst <= (w_state_d == StClear) && (w_clr_cnt_d == ClearLast);
      r_timer_on    <= (w_state_d == StRun);
      r_busy        <= (w_state_d != StIdle) && (w_state_d != StDone);
      r_done        <= (w_state_d == StDone);
    end
  end

  assign bus.fifo_rst      = r_fifo_rst;
  assign bus.pattern_rst   = r_pattern_rst;
  assign bus.timer_on      = r_timer_on;
  assign bus.clk_counts    = r_clk_counts;
  assign bus.words_written = r_words_written;
  assign bus.words_checked = r_words_checked;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.status        = r_status;
  assign bus.state         = r_state;

endmodule

// File: tb/tb_write_test_sequencer.sv
// tb_write_test_sequencer: scenario tasks drive runs; a scoreboard queue holds the expected
// end-of-run results, popped and compared by a monitor each time done rises.
module tb_write_test_sequencer;
  localparam int unsigned ClearCycles   = 4;
  localparam int unsigned TimeoutCycles = 16;

  typedef struct {
    logic [63:0] clk_counts;
    logic [31:0] written;
    logic [31:0] checked;
    logic [2:0]  status;
  } exp_t;

  logic okClk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  write_test_sequencer_if bus ();

  write_test_sequencer #(
    .CLEAR_CYCLES  (ClearCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .okClk  (okClk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 okClk = ~okClk;

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  // Issue start and step through CLEAR; returns in the first ARMED cycle.
  task automatic start_run(input logic [31:0] len);
    bus.transfer_words = len;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (ClearCycles) tick();
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Scoreboard monitor: compare end-of-run results on each rising done.
  initial begin : sb_monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(posedge okClk);
      #1;
      if (bus.done === 1'b1 && !prev_done) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected_done: done rose, expected no run to end");
        end else begin
          e = sb_q.pop_front();
          if (bus.clk_counts !== e.clk_counts) begin
            n_errors++;
            $display("FAIL sb_clk_counts: got %0d expected %0d", bus.clk_counts, e.clk_counts);
          end
          n_checks++;
          if (bus.words_written !== e.written) begin
            n_errors++;
            $display("FAIL sb_words_written: got %0d expected %0d", bus.words_written, e.written);
          end
          n_checks++;
          if (bus.words_checked !== e.checked) begin
            n_errors++;
            $display("FAIL sb_words_checked: got %0d expected %0d", bus.words_checked, e.checked);
          end
          n_checks++;
          if (bus.status !== e.status) begin
            n_errors++;
            $display("FAIL sb_status: got %0d expected %0d", bus.status, e.status);
          end
        end
      end
      prev_done = (bus.done === 1'b1);
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.transfer_words = '0;
    bus.wr_strobe = 1'b0;
    bus.rd_valid = 1'b0;
    bus.error_count = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d busy=%b done=%b expected 0/0/0",
               bus.state, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.fifo_rst !== 1'b0 || bus.pattern_rst !== 1'b0 || bus.timer_on !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: fifo_rst=%b pattern_rst=%b timer_on=%b expected 0",
               bus.fifo_rst, bus.pattern_rst, bus.timer_on);
    end
    n_checks++;
    if (bus.clk_counts !== 64'd0 || bus.words_written !== 32'd0 ||
        bus.words_checked !== 32'd0 || bus.status !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_counters: clk=%0d ww=%0d wc=%0d status=%0d expected all 0",
               bus.clk_counts, bus.words_written, bus.words_checked, bus.status);
    end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    bit got;
    sb_q.push_back('{clk_counts: 64'd8, written: 32'd8, checked: 32'd8, status: 3'd0});
    bus.transfer_words = 32'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= int'(ClearCycles); c++) begin
      n_checks++;
      if (bus.fifo_rst !== 1'b1 || bus.state !== 3'd1) begin
        n_errors++;
        $display("FAIL clear_fifo_rst: cycle %0d fifo_rst=%b state=%0d expected 1/1",
                 c, bus.fifo_rst, bus.state);
      end
      n_checks++;
      if (bus.pattern_rst !== 1'(c == int'(ClearCycles))) begin
        n_errors++;
        $display("FAIL clear_pattern_rst: cycle %0d got %b expected %b",
                 c, bus.pattern_rst, (c == int'(ClearCycles)));
      end
      tick();
    end
    n_checks++;
    if (bus.state !== 3'd2 || bus.fifo_rst !== 1'b0 || bus.timer_on !== 1'b0) begin
      n_errors++;
      $display("FAIL armed_entry: state=%0d fifo_rst=%b timer_on=%b expected 2/0/0",
               bus.state, bus.fifo_rst, bus.timer_on);
    end
    bus.wr_strobe = 1'b1;
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) begin
        n_checks++;
        if (bus.timer_on !== 1'b1 || bus.state !== 3'd3) begin
          n_errors++;
          $display("FAIL timer_start: timer_on=%b state=%0d expected 1/3",
                   bus.timer_on, bus.state);
        end
      end
    end
    bus.wr_strobe = 1'b0;
    bus.rd_valid = 1'b0;
    n_checks++;
    if (bus.timer_on !== 1'b0 || bus.state !== 3'd4) begin
      n_errors++;
      $display("FAIL timer_stop: timer_on=%b state=%0d expected 0/4", bus.timer_on, bus.state);
    end
    wait_done(got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL basic_done: done=0 expected 1 within bound");
    end
  endtask

  task automatic test_gapped_writes();
    bit got;
    int first_wr;
    int last_wr;
    first_wr = 0;
    last_wr = 9;
    sb_q.push_back('{clk_counts: 64'(last_wr - first_wr + 1), written: 32'd4, checked: 32'd4,
                     status: 3'd0});
    start_run(32'd4);
    for (int c = 0; c <= 9; c++) begin
      bus.wr_strobe = (c == 0 || c == 2 || c == 4 || c == 9);
      tick();
    end
    bus.wr_strobe = 1'b0;
    n_checks++;
    if (bus.words_written !== 32'd4 || bus.state !== 3'd4) begin
      n_errors++;
      $display("FAIL gapped_written: ww=%0d state=%0d expected 4/4",
               bus.words_written, bus.state);
    end
    bus.rd_valid = 1'b1;
    repeat (4) tick();
    bus.rd_valid = 1'b0;
    wait_done(got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL gapped_done: done=0 expected 1 within bound");
    end
  endtask

  task automatic test_errors();
    bit got;
    sb_q.push_back('{clk_counts: 64'd4, written: 32'd4, checked: 32'd4, status: 3'd1});
    start_run(32'd4);
    bus.wr_strobe = 1'b1;
    repeat (4) tick();
    bus.wr_strobe = 1'b0;
    bus.error_count = 32'd3;
    bus.rd_valid = 1'b1;
    repeat (4) tick();
    bus.rd_valid = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_errors++;
      $display("FAIL done_latency: done=%b expected 1 one cycle after final rd_valid", bus.done);
    end
    wait_done(got);
    bus.error_count = '0;
  endtask

  task automatic test_overrun();
    bit got;
    sb_q.push_back('{clk_counts: 64'd4, written: 32'd4, checked: 32'd4, status: 3'd4});
    start_run(32'd4);
    bus.wr_strobe = 1'b1;
    repeat (5) tick();  // fifth write lands in DRAIN
    bus.wr_strobe = 1'b0;
    n_checks++;
    if (bus.words_written !== 32'd4 || bus.state !== 3'd4) begin
      n_errors++;
      $display("FAIL overrun_uncounted: ww=%0d state=%0d expected 4/4",
               bus.words_written, bus.state);
    end
    bus.error_count = 32'd3;
    bus.rd_valid = 1'b1;
    repeat (4) tick();
    bus.rd_valid = 1'b0;
    wait_done(got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL overrun_done: done=0 expected 1 within bound");
    end
    bus.error_count = '0;
  endtask

  task automatic test_abort();
    logic [63:0] frozen;
    sb_q.push_back('{clk_counts: 64'd3, written: 32'd2, checked: 32'd0, status: 3'd2});
    start_run(32'd8);
    bus.wr_strobe = 1'b1;
    repeat (2) tick();
    bus.wr_strobe = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.state !== 3'd5 || bus.done !== 1'b1 || bus.timer_on !== 1'b0 ||
        bus.status !== 3'd2) begin
      n_errors++;
      $display("FAIL abort_next_cycle: state=%0d done=%b timer_on=%b status=%0d expected 5/1/0/2",
               bus.state, bus.done, bus.timer_on, bus.status);
    end
    frozen = 64'd3;
    repeat (3) tick();
    n_checks++;
    if (bus.clk_counts !== frozen) begin
      n_errors++;
      $display("FAIL abort_frozen: clk_counts=%0d expected %0d", bus.clk_counts, frozen);
    end
    // Abort coinciding with start in DONE: start must be dropped.
    bus.transfer_words = 32'd4;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_checks++;
    if (bus.state !== 3'd5 || bus.clk_counts !== frozen) begin
      n_errors++;
      $display("FAIL abort_beats_start: state=%0d clk=%0d expected 5/%0d",
               bus.state, bus.clk_counts, frozen);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    sb_q.push_back('{clk_counts: 64'd1, written: 32'd1, checked: 32'd1, status: 3'd0});
    bus.transfer_words = 32'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++;
    if (bus.clk_counts !== 64'd0 || bus.words_written !== 32'd0 || bus.status !== 3'd0 ||
        bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_clear: clk=%0d ww=%0d status=%0d done=%b expected 0/0/0/0",
               bus.clk_counts, bus.words_written, bus.status, bus.done);
    end
    repeat (ClearCycles) tick();
    bus.wr_strobe = 1'b1;
    bus.rd_valid = 1'b1;
    tick();
    bus.wr_strobe = 1'b0;
    bus.rd_valid = 1'b0;
    n_checks++;
    if (bus.state !== 3'd4 || bus.timer_on !== 1'b0) begin
      n_errors++;
      $display("FAIL single_word: state=%0d timer_on=%b expected 4/0", bus.state, bus.timer_on);
    end
    wait_done(got);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL single_word_done: done=0 expected 1 within bound");
    end
  endtask

  task automatic test_async_reset();
    start_run(32'd4);
    bus.wr_strobe = 1'b1;
    repeat (4) tick();
    bus.wr_strobe = 1'b0;
    n_checks++;
    if (bus.state !== 3'd4 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_drain: state=%0d busy=%b expected 4/1", bus.state, bus.busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.clk_counts !== 64'd0 ||
        bus.words_written !== 32'd0 || bus.fifo_rst !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: state=%0d busy=%b clk=%0d ww=%0d fifo_rst=%b expected 0",
               bus.state, bus.busy, bus.clk_counts, bus.words_written, bus.fifo_rst);
    end
    tick();
    reset_n = 1'b1;
    tick();
    bus.transfer_words = 32'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    n_checks++;
    if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.fifo_rst !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_length_start: state=%0d busy=%b fifo_rst=%b expected 0/0/0",
               bus.state, bus.busy, bus.fifo_rst);
    end
  endtask

`ifdef WTS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    sb_q.push_back('{clk_counts: 64'd0, written: 32'd0, checked: 32'd0, status: 3'd3});
    start_run(32'd4);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) break;
      tick();
      n++;
    end
    n_checks++;
    if (n != int'(TimeoutCycles) || bus.timer_on !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_latency: done after %0d cycles timer_on=%b expected %0d/0",
               n, bus.timer_on, TimeoutCycles);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gapped_writes();
    test_errors();
    test_overrun();
    test_abort();
    test_back_to_back();
`ifdef WTS_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    repeat (2) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: %0d expected runs never completed, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/write_test_sequencer.md
# write_test_sequencer

Test-sequencing controller for the 32-bit pipe-in write throughput test. It owns the FIFO reset, the pattern-checker reset, the 64-bit clock-count timer and word accounting, and it ends a run automatically once a host-programmed number of words has been written and checked. It sits between the host trigger/wire endpoints and the FIFO/checker datapath, replacing host-driven start/stop timer triggers with hardware-exact timing.

## Interface
Parameters:
- CLEAR_CYCLES, 4, cycles `fifo_rst` is held high in CLEAR (≥1)
- TIMEOUT_CYCLES, 1000000, idle-write watchdog limit (used only with `WTS_TIMEOUT_EN`)

Ports:
- okClk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle run request
- abort  in  1  single-cycle run cancel
- transfer_words  in  32  words expected per run, latched on accepted `start`
- wr_strobe  in  1  pipe-in write strobe (FIFO write enable)
- rd_valid  in  1  FIFO output valid, one per word checked
- error_count  in  32  checker error counter
- fifo_rst  out  1  FIFO reset, high in CLEAR
- pattern_rst  out  1  checker pattern/error reset pulse
- timer_on  out  1  timer running
- clk_counts  out  64  measured write cycles
- words_written  out  32  writes counted this run
- words_checked  out  32  `rd_valid` beats counted this run
- busy  out  1  state ≠ IDLE and ≠ DONE
- done  out  1  state = DONE
- status  out  3  0 ok, 1 data errors, 2 aborted, 3 timeout, 4 overrun
- state  out  3  IDLE=0, CLEAR=1, ARMED=2, RUN=3, DRAIN=4, DONE=5

## Operation
- Reset: all outputs 0, state IDLE, latched length 0.
- IDLE/DONE: `start` with `transfer_words`≠0 latches length, clears `clk_counts`, word counters and `status`, then enters CLEAR. `start` with 0 is ignored. `start` in any other state is ignored.
- CLEAR: `fifo_rst`=1 for exactly CLEAR_CYCLES cycles. `pattern_rst`=1 only on the last CLEAR cycle. Then ARMED.
- ARMED: timer stopped. First `wr_strobe` enters RUN; that write is counted and timed.
- RUN: `timer_on`=1; `clk_counts` increments every cycle. Every `wr_strobe` increments `words_written`. On the cycle the write makes `words_written` equal the latched length, go to DRAIN. The timer counts that cycle and then stops.
- DRAIN: wait until `words_checked` equals the length, then go to DONE.
- Word counting: `rd_valid` increments `words_checked` in ARMED/RUN/DRAIN, saturating at the length.
- DONE: final status is latched on entry. Priority is abort > timeout > overrun > errors (`error_count`≠0) > ok. Counters hold until next `start`.
- Overrun: `wr_strobe` in DRAIN sets a sticky overrun flag. The write is not counted.
- Abort: `abort` in CLEAR/ARMED/RUN/DRAIN goes to DONE next cycle with status 2 and `timer_on`=0. `abort` in IDLE/DONE is ignored. If `abort` and `start` coincide, `abort` wins.
- Async reset mid-run returns immediately to IDLE with all outputs 0.

## Timing
- `start` at cycle 0 → state CLEAR at cycle 1, `fifo_rst` high cycles 1..CLEAR_CYCLES, `pattern_rst` at cycle CLEAR_CYCLES, ARMED at cycle CLEAR_CYCLES+1.
- First write at cycle t → `timer_on` registered high at t+1. Last write at cycle u → `clk_counts` = u−t+1, `timer_on` low at u+1.
- All outputs are registered; `done` rises one cycle after the final `rd_valid` is sampled.
- `clk_counts` wraps modulo 2^64. No saturation is required.

## Configuration
- `WTS_TIMEOUT_EN` defined: a watchdog counter in ARMED/RUN/DRAIN is cleared by any `wr_strobe` or `rd_valid`. When it reaches TIMEOUT_CYCLES, the block goes to DONE with status 3 and the timer stopped.
- Not defined: no watchdog logic. A run waits indefinitely; status 3 never occurs.

## Test plan
- Length 8, 8 back-to-back writes, 8 `rd_valid`, `error_count`=0 → `clk_counts`=8, status 0, `done`=1.
- Length 4, writes on cycles t, t+2, t+4, t+9 → `clk_counts`=10, `words_written`=4.
- Length 4 with `error_count`=3 at DRAIN exit → status 1. A 5th write during DRAIN → status 4 instead.
- `abort` mid-RUN after 2 of 8 writes → DONE next cycle, status 2, `clk_counts` frozen.
- `reset_n` low mid-DRAIN → outputs 0 and state IDLE within the same cycle. `start` with `transfer_words`=0 → stays IDLE.
- With `WTS_TIMEOUT_EN`, TIMEOUT_CYCLES=16, no writes after ARMED → DONE after 16 cycles, status 3.
